// File: rtl/pspin_cfg_pkg.sv
// PsPIN configuration: command request/response types, interface IDs and
// the command router's default per-cluster outstanding limit.
package pspin_cfg_pkg;

    localparam int NUM_CLUSTERS       = 4;
    localparam int NUM_CORES          = 8;
    localparam int NUM_HPU_CMDS       = 4;
    localparam int NUM_CMD_INTERFACES = 3;

    localparam int CMD_HOSTDIRECT_ID   = 0;
    localparam int CMD_NIC_OUTBOUND_ID = 1;
    localparam int CMD_EDMA_ID         = 2;

    localparam int CMD_ROUTER_MAX_OUTSTANDING = NUM_CORES * NUM_HPU_CMDS;

    localparam int CLUSTER_ID_W = $clog2(NUM_CLUSTERS);
    localparam int CORE_ID_W    = $clog2(NUM_CORES);
    localparam int HPU_CMD_ID_W = $clog2(NUM_HPU_CMDS);
    // Wide enough to carry out-of-range IDs so the router can detect them
    localparam int INTF_ID_W    = 2;
    localparam int CMD_DESCR_W  = 64;

    typedef struct packed {
        logic [CLUSTER_ID_W-1:0] cluster_id;
        logic [CORE_ID_W-1:0]    core_id;
        logic [HPU_CMD_ID_W-1:0] local_cmd_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        pspin_cmd_id_t          cmd_id;
        logic                   generate_event;
        logic [INTF_ID_W-1:0]   intf_id;
        logic [CMD_DESCR_W-1:0] descr;
    } pspin_cmd_req_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
    } pspin_cmd_resp_t;

endpackage

// File: rtl/cmd_rr_arbiter.sv
// Round-robin arbiter with one-hot grant; the priority pointer moves to the
// slot after the winner only when the caller reports the grant was taken.
module cmd_rr_arbiter #(
    parameter int   WIDTH = 4,
    localparam int  IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic             advance,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;

    function automatic logic [IDX_W-1:0] wrap(input int unsigned v);
        return IDX_W'(v % WIDTH);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        any       = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!any && req[wrap(32'(ptr) + 32'(i))]) begin
                any       = 1'b1;
                grant_idx = wrap(32'(ptr) + 32'(i));
            end
        end
        grant[grant_idx] = any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= wrap(32'(grant_idx) + 32'd1);
        end
    end

endmodule

// File: rtl/pspin_cmd_router.sv
// Registered round-robin crossbar: cluster commands to interfaces by intf_id,
// responses back by cluster_id. Define PSPIN_CMD_ROUTER_CREDIT_EN for credits.
module pspin_cmd_router
    import pspin_cfg_pkg::*;
#(
    parameter int NUM_CLUSTERS    = pspin_cfg_pkg::NUM_CLUSTERS,
    parameter int NUM_INTF        = pspin_cfg_pkg::NUM_CMD_INTERFACES,
    parameter int MAX_OUTSTANDING = pspin_cfg_pkg::CMD_ROUTER_MAX_OUTSTANDING
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic [NUM_CLUSTERS-1:0] cmd_req_valid_i,
    output logic [NUM_CLUSTERS-1:0] cmd_req_ready_o,
    input  pspin_cmd_req_t          cmd_req_i [NUM_CLUSTERS],

    output logic [NUM_INTF-1:0]     intf_req_valid_o,
    input  logic [NUM_INTF-1:0]     intf_req_ready_i,
    output pspin_cmd_req_t          intf_req_o,

    input  logic [NUM_INTF-1:0]     intf_resp_valid_i,
    output logic [NUM_INTF-1:0]     intf_resp_ready_o,
    input  pspin_cmd_resp_t         intf_resp_i [NUM_INTF],

    output logic [NUM_CLUSTERS-1:0] cluster_resp_valid_o,
    input  logic [NUM_CLUSTERS-1:0] cluster_resp_ready_i,
    output pspin_cmd_resp_t         cluster_resp_o,

    output logic                    bad_intf_o
);

    localparam int CIDX_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int IIDX_W = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1;

    logic [NUM_CLUSTERS-1:0] credit_ok;
    logic [NUM_CLUSTERS-1:0] eligible;
    logic [NUM_CLUSTERS-1:0] req_grant;
    logic [CIDX_W-1:0]       req_idx;
    logic                    req_any;
    logic                    req_full;
    logic                    req_out_hs;
    logic                    req_loadable;
    logic                    req_accept;
    logic                    req_bad;
    pspin_cmd_req_t          req_sel;

    logic [NUM_INTF-1:0]     resp_grant;
    logic [IIDX_W-1:0]       resp_idx;
    logic                    resp_any;
    logic                    resp_full;
    logic                    resp_out_hs;
    logic                    resp_loadable;
    logic                    resp_accept;
    logic                    resp_in_range;
    pspin_cmd_resp_t         resp_sel;

    function automatic logic [NUM_INTF-1:0] intf_onehot(input logic [INTF_ID_W-1:0] id);
        intf_onehot = '0;
        for (int i = 0; i < NUM_INTF; i++) begin
            intf_onehot[i] = (int'(id) == i);
        end
    endfunction

    function automatic logic [NUM_CLUSTERS-1:0] cluster_onehot(input logic [CLUSTER_ID_W-1:0] id);
        cluster_onehot = '0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            cluster_onehot[i] = (int'(id) == i);
        end
    endfunction

    // ---------------------------------------------------------------- request path
    assign eligible     = cmd_req_valid_i & credit_ok;
    assign req_out_hs   = |(intf_req_valid_o & intf_req_ready_i);
    assign req_loadable = !req_full || req_out_hs;
    assign req_accept   = req_any && req_loadable;
    assign req_sel      = cmd_req_i[req_idx];
    assign req_bad      = int'(req_sel.intf_id) >= NUM_INTF;

    assign cmd_req_ready_o = req_loadable ? req_grant : '0;

    cmd_rr_arbiter #(
        .WIDTH (NUM_CLUSTERS)
    ) u_req_arb (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .req       (eligible),
        .advance   (req_loadable),
        .grant     (req_grant),
        .grant_idx (req_idx),
        .any       (req_any)
    );

    // A bad-ID request is consumed but never occupies the register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_full         <= 1'b0;
            intf_req_valid_o <= '0;
            intf_req_o       <= '0;
            bad_intf_o       <= 1'b0;
        end else begin
            bad_intf_o <= req_accept && req_bad;
            if (req_accept && !req_bad) begin
                req_full         <= 1'b1;
                intf_req_valid_o <= intf_onehot(req_sel.intf_id);
                intf_req_o       <= req_sel;
            end else if (req_out_hs) begin
                req_full         <= 1'b0;
                intf_req_valid_o <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- response path
    assign resp_out_hs   = |(cluster_resp_valid_o & cluster_resp_ready_i);
    assign resp_loadable = !resp_full || resp_out_hs;
    assign resp_accept   = resp_any && resp_loadable;
    assign resp_sel      = intf_resp_i[resp_idx];
    assign resp_in_range = int'(resp_sel.cmd_id.cluster_id) < NUM_CLUSTERS;

    assign intf_resp_ready_o = resp_loadable ? resp_grant : '0;

    cmd_rr_arbiter #(
        .WIDTH (NUM_INTF)
    ) u_resp_arb (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .req       (intf_resp_valid_i),
        .advance   (resp_loadable),
        .grant     (resp_grant),
        .grant_idx (resp_idx),
        .any       (resp_any)
    );

    // Responses naming a nonexistent cluster are dropped rather than wedging the register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_full            <= 1'b0;
            cluster_resp_valid_o <= '0;
            cluster_resp_o       <= '0;
        end else begin
            if (resp_accept && resp_in_range) begin
                resp_full            <= 1'b1;
                cluster_resp_valid_o <= cluster_onehot(resp_sel.cmd_id.cluster_id);
                cluster_resp_o       <= resp_sel;
            end else if (resp_out_hs) begin
                resp_full            <= 1'b0;
                cluster_resp_valid_o <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- credits
`ifdef PSPIN_CMD_ROUTER_CREDIT_EN
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [CNT_W-1:0]        credit_cnt [NUM_CLUSTERS];
    logic [NUM_CLUSTERS-1:0] credit_inc;
    logic [NUM_CLUSTERS-1:0] credit_dec;

    assign credit_inc = (req_accept && !req_bad) ? req_grant : '0;
    assign credit_dec = cluster_resp_valid_o & cluster_resp_ready_i;

    always_comb begin
        credit_ok = '0;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            credit_ok[c] = (credit_cnt[c] != CNT_W'(MAX_OUTSTANDING));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                credit_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                if (credit_inc[c] && !credit_dec[c]) begin
                    credit_cnt[c] <= credit_cnt[c] + CNT_W'(1);
                end else if (credit_dec[c] && !credit_inc[c] && (credit_cnt[c] != '0)) begin
                    credit_cnt[c] <= credit_cnt[c] - CNT_W'(1);
                end
            end
        end
    end
`else
    // Without credits every valid cluster competes; a zero limit still blocks all
    assign credit_ok = (MAX_OUTSTANDING > 0) ? '1 : '0;
`endif

endmodule

// File: tb/tb_pspin_cmd_router.sv
// Directed bench for pspin_cmd_router; covers the credit limit when
// PSPIN_CMD_ROUTER_CREDIT_EN is defined.
module tb_pspin_cmd_router;
    import pspin_cfg_pkg::*;

    localparam int NC = 4;
    localparam int NI = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   cmd_req_valid;
    logic [NC-1:0]   cmd_req_ready;
    pspin_cmd_req_t  cmd_req [NC];
    logic [NI-1:0]   intf_req_valid;
    logic [NI-1:0]   intf_req_ready;
    pspin_cmd_req_t  intf_req;
    logic [NI-1:0]   intf_resp_valid;
    logic [NI-1:0]   intf_resp_ready;
    pspin_cmd_resp_t intf_resp [NI];
    logic [NC-1:0]   cluster_resp_valid;
    logic [NC-1:0]   cluster_resp_ready;
    pspin_cmd_resp_t cluster_resp;
    logic            bad_intf;

    int n_cmp = 0;
    int n_err = 0;

    pspin_cmd_req_t  r2, ra, rb, rbad, rrst;
    pspin_cmd_req_t  rr_req [NC];
    pspin_cmd_resp_t rsp0, rsp2, rsp1;

    always #5 clk = ~clk;

    pspin_cmd_router #(
        .NUM_CLUSTERS    (NC),
        .NUM_INTF        (NI),
        .MAX_OUTSTANDING (32)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .cmd_req_valid_i      (cmd_req_valid),
        .cmd_req_ready_o      (cmd_req_ready),
        .cmd_req_i            (cmd_req),
        .intf_req_valid_o     (intf_req_valid),
        .intf_req_ready_i     (intf_req_ready),
        .intf_req_o           (intf_req),
        .intf_resp_valid_i    (intf_resp_valid),
        .intf_resp_ready_o    (intf_resp_ready),
        .intf_resp_i          (intf_resp),
        .cluster_resp_valid_o (cluster_resp_valid),
        .cluster_resp_ready_i (cluster_resp_ready),
        .cluster_resp_o       (cluster_resp),
        .bad_intf_o           (bad_intf)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pspin_cmd_req_t mk_req(input int cl, input int intf, input logic [63:0] d);
        pspin_cmd_req_t r;
        r = '0;
        r.cmd_id.cluster_id   = CLUSTER_ID_W'(cl);
        r.cmd_id.core_id      = CORE_ID_W'(cl + 1);
        r.cmd_id.local_cmd_id = HPU_CMD_ID_W'(intf);
        r.generate_event      = 1'b1;
        r.intf_id             = INTF_ID_W'(intf);
        r.descr               = d;
        return r;
    endfunction

    function automatic pspin_cmd_resp_t mk_resp(input int cl, input int core);
        pspin_cmd_resp_t r;
        r = '0;
        r.cmd_id.cluster_id   = CLUSTER_ID_W'(cl);
        r.cmd_id.core_id      = CORE_ID_W'(core);
        r.cmd_id.local_cmd_id = HPU_CMD_ID_W'(core);
        return r;
    endfunction

    task automatic clear_inputs();
        cmd_req_valid      = '0;
        intf_req_ready     = 3'b111;
        intf_resp_valid    = '0;
        cluster_resp_ready = 4'b1111;
        for (int c = 0; c < NC; c++) cmd_req[c] = '0;
        for (int i = 0; i < NI; i++) intf_resp[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        r2   = mk_req(2, 1, 64'h0123_4567_89AB_CDEF);
        ra   = mk_req(0, 2, 64'hAAAA_0000_0000_00A2);
        rb   = mk_req(0, 0, 64'hBBBB_0000_0000_00B0);
        rbad = mk_req(1, 3, 64'hDEAD_0000_0000_0003);
        rrst = mk_req(0, 2, 64'h5555_0000_0000_0002);
        for (int c = 0; c < NC; c++) rr_req[c] = mk_req(c, 0, 64'hC0DE_0000_0000_0000 + 64'(c));
        rsp0 = mk_resp(3, 5);
        rsp2 = mk_resp(1, 6);
        rsp1 = mk_resp(0, 7);

        // Reset state
        @(negedge clk); #1;
        chk("rst_intf_vld", 128'(intf_req_valid), 128'(3'b000));
        chk("rst_cmd_rdy", 128'(cmd_req_ready), 128'(4'b0000));
        chk("rst_clu_vld", 128'(cluster_resp_valid), 128'(4'b0000));
        chk("rst_resp_rdy", 128'(intf_resp_ready), 128'(3'b000));
        chk("rst_bad", 128'(bad_intf), 128'(1'b0));
        chk("rst_req_pay", 128'(intf_req), 128'(0));
        chk("rst_resp_pay", 128'(cluster_resp), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Cluster 2 to NIC outbound
        @(negedge clk);
        cmd_req[2] = r2;
        cmd_req_valid = 4'b0100;
        #1;
        chk("c2_ready", 128'(cmd_req_ready), 128'(4'b0100));
        @(negedge clk);
        cmd_req_valid = '0;
        #1;
        chk("c2_vld", 128'(intf_req_valid), 128'(3'b010));
        chk("c2_payload", 128'(intf_req), 128'(r2));
        @(negedge clk); #1;
        chk("c2_drained", 128'(intf_req_valid), 128'(3'b000));

        // Round robin across all clusters, one acceptance per cycle
        do_reset();
        @(negedge clk);
        for (int c = 0; c < NC; c++) cmd_req[c] = rr_req[c];
        cmd_req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("rr_grant%0d", k), 128'(cmd_req_ready), 128'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk($sformatf("rr_vld%0d", k), 128'(intf_req_valid), 128'(3'b001));
                chk($sformatf("rr_pay%0d", k), 128'(intf_req), 128'(rr_req[(k - 1) % 4]));
            end
        end
        @(negedge clk);
        cmd_req_valid = '0;
        #1;
        chk("rr_last_vld", 128'(intf_req_valid), 128'(3'b001));
        chk("rr_last_pay", 128'(intf_req), 128'(rr_req[0]));

        // Backpressure from eDMA for 5 cycles
        do_reset();
        @(negedge clk);
        cmd_req[0] = ra;
        cmd_req_valid = 4'b0001;
        intf_req_ready = 3'b000;
        #1;
        chk("bp_first_rdy", 128'(cmd_req_ready), 128'(4'b0001));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cmd_req[0] = rb;
            #1;
            chk($sformatf("bp_vld%0d", k), 128'(intf_req_valid), 128'(3'b100));
            chk($sformatf("bp_pay%0d", k), 128'(intf_req), 128'(ra));
            chk($sformatf("bp_rdy%0d", k), 128'(cmd_req_ready), 128'(4'b0000));
        end
        @(negedge clk);
        intf_req_ready = 3'b100;
        #1;
        chk("bp_release_rdy", 128'(cmd_req_ready), 128'(4'b0001));
        chk("bp_release_vld", 128'(intf_req_valid), 128'(3'b100));
        @(negedge clk);
        cmd_req_valid = '0;
        intf_req_ready = 3'b111;
        #1;
        chk("bp_next_vld", 128'(intf_req_valid), 128'(3'b001));
        chk("bp_next_pay", 128'(intf_req), 128'(rb));
        @(negedge clk); #1;
        chk("bp_drained", 128'(intf_req_valid), 128'(3'b000));

        // Out-of-range interface ID
        @(negedge clk);
        cmd_req[1] = rbad;
        cmd_req_valid = 4'b0010;
        #1;
        chk("bad_rdy", 128'(cmd_req_ready), 128'(4'b0010));
        chk("bad_pre", 128'(bad_intf), 128'(1'b0));
        @(negedge clk);
        cmd_req_valid = '0;
        #1;
        chk("bad_pulse", 128'(bad_intf), 128'(1'b1));
        chk("bad_no_vld", 128'(intf_req_valid), 128'(3'b000));
        @(negedge clk); #1;
        chk("bad_end", 128'(bad_intf), 128'(1'b0));
        chk("bad_no_vld2", 128'(intf_req_valid), 128'(3'b000));

        // Asynchronous reset discards a held command
        @(negedge clk);
        cmd_req[0] = rrst;
        cmd_req_valid = 4'b0001;
        intf_req_ready = 3'b000;
        @(negedge clk);
        cmd_req_valid = '0;
        #1;
        chk("arst_held", 128'(intf_req_valid), 128'(3'b100));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 128'(intf_req_valid), 128'(3'b000));
        chk("arst_pay", 128'(intf_req), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        intf_req_ready = 3'b111;

        // Responses from interfaces 0 and 2
        do_reset();
        @(negedge clk);
        intf_resp[0] = rsp0;
        intf_resp[2] = rsp2;
        intf_resp_valid = 3'b101;
        #1;
        chk("rsp_rdy0", 128'(intf_resp_ready), 128'(3'b001));
        @(negedge clk);
        intf_resp_valid = 3'b100;
        #1;
        chk("rsp_vld_c3", 128'(cluster_resp_valid), 128'(4'b1000));
        chk("rsp_pay_c3", 128'(cluster_resp), 128'(rsp0));
        chk("rsp_rdy2", 128'(intf_resp_ready), 128'(3'b100));
        @(negedge clk);
        intf_resp_valid = '0;
        #1;
        chk("rsp_vld_c1", 128'(cluster_resp_valid), 128'(4'b0010));
        chk("rsp_pay_c1", 128'(cluster_resp), 128'(rsp2));
        @(negedge clk); #1;
        chk("rsp_drained", 128'(cluster_resp_valid), 128'(4'b0000));

        // Response held while the cluster is not ready
        @(negedge clk);
        intf_resp[1] = rsp1;
        intf_resp_valid = 3'b010;
        cluster_resp_ready = 4'b0000;
        @(negedge clk);
        intf_resp_valid = '0;
        #1;
        chk("hold_vld0", 128'(cluster_resp_valid), 128'(4'b0001));
        @(negedge clk); #1;
        chk("hold_vld1", 128'(cluster_resp_valid), 128'(4'b0001));
        chk("hold_pay", 128'(cluster_resp), 128'(rsp1));
        cluster_resp_ready = 4'b1111;
        @(negedge clk); #1;
        chk("hold_done", 128'(cluster_resp_valid), 128'(4'b0000));

`ifdef PSPIN_CMD_ROUTER_CREDIT_EN
        // 32 outstanding commands exhaust cluster 0's credit
        do_reset();
        @(negedge clk);
        cmd_req[0] = rb;
        cmd_req_valid = 4'b0001;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("cr_acc%0d", k), 128'(cmd_req_ready), 128'(4'b0001));
        end
        @(negedge clk); #1;
        chk("cr_stall", 128'(cmd_req_ready), 128'(4'b0000));
        intf_resp[0] = rsp1;
        intf_resp_valid = 3'b001;
        @(negedge clk);
        intf_resp_valid = '0;
        #1;
        chk("cr_resp_vld", 128'(cluster_resp_valid), 128'(4'b0001));
        chk("cr_still_stall", 128'(cmd_req_ready), 128'(4'b0000));
        @(negedge clk); #1;
        chk("cr_reenabled", 128'(cmd_req_ready), 128'(4'b0001));
        @(negedge clk);
        cmd_req_valid = '0;
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
